stream_mux_n: RTL and testbench
===============================

Name: stream_mux_n

Overview:
- Parametrised N-channel, W-bit successor to the team's combinational 8:1 mux.
- Adds per-channel valid/ready handshakes and one registered output stage with back-pressure.
- Two grant modes: fixed select (legacy behaviour) or round-robin fair arbitration.
- Sits between multiple producer streams and a single consumer, e.g. sensor/UART channel aggregation.

Parameters:
- N_CH, 8, number of input channels (2..16).
- DATA_W, 8, data width per channel.
- SEL_W, $clog2(N_CH), width of select/channel-ID fields (derived, do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel select, used in fixed mode only.
- in_data  in  N_CH*DATA_W  packed channel data; channel i occupies [i*DATA_W +: DATA_W].
- in_valid  in  N_CH  per-channel valid.
- in_ready  out  N_CH  per-channel ready (one-hot or zero).
- out_data  out  DATA_W  registered output data.
- out_ch  out  SEL_W  channel index of the word in out_data.
- out_valid  out  1  output valid.
- out_ready  in  1  consumer ready.
- sel_err  out  1  registered flag: fixed mode with sel >= N_CH.

Behaviour:
- Reset (synchronous, rst=1 at clk edge): out_valid=0, out_data=0, out_ch=0, sel_err=0, rr_ptr=N_CH-1.
  - With rr_ptr=N_CH-1, the first round-robin search starts at channel 0.
  - Reset mid-transfer discards the held word; no handshake completes in the reset cycle.
- load_en = !out_valid | out_ready. This gives full throughput: one word per cycle when the consumer is always ready.
- Grant, fixed mode: gnt = sel if sel < N_CH and in_valid[sel]; otherwise no grant.
- Grant, RR mode: gnt = first i with in_valid[i], searching rr_ptr+1, rr_ptr+2, ... and wrapping modulo N_CH; no grant if in_valid=0.
- in_ready[i] = load_en & grant_valid & (gnt==i). All bits are combinational; at most one bit is set.
- Input handshake (in_valid[i] & in_ready[i]) at a clk edge:
  - out_data <= channel i data, out_ch <= i, out_valid <= 1.
  - In RR mode, rr_ptr <= i.
- rr_ptr is updated only on a completed handshake in RR mode. It holds in fixed mode.
- Output handshake (out_valid & out_ready) with no new grant: out_valid <= 0, out_data holds its last value.
- Back-pressure: while out_valid & !out_ready, out_data, out_ch and out_valid are held stable and in_ready is all zero.
- Latency: input handshake at edge k produces out_valid at edge k, visible in cycle k+1.
- Simultaneous output consume and new input grant in the same cycle: the register reloads, out_valid stays 1, and there is no bubble.
- Mode switch: takes effect at the next grant decision. The held output word is unaffected. rr_ptr keeps its last value.
- sel_err <= (mode==0) & (sel >= N_CH), registered every cycle. It is never set when N_CH is a power of two.
- An out-of-range sel never asserts any in_ready bit.
- Arithmetic:
  - RR wrap index = (rr_ptr + 1 + k) mod N_CH, computed at SEL_W+1 bits to avoid overflow for non-power-of-two N_CH.
  - Data is passed through unmodified.

Decomposition:
- Package stream_mux_pkg:
  - mode encodings MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - function clog2_min1, so that N_CH=1 yields SEL_W=1.
- Sub-module rr_arbiter_n (params N_CH, SEL_W):
  - inputs req[N_CH], ptr.
  - outputs gnt_valid, gnt_idx.
  - purely combinational priority rotate.
- The top level owns the output register, rr_ptr update, fixed-mode path and sel_err.

Test Plan:
1. Fixed mode, sel=3, in_valid=8'hFF, ch3 data=8'hA5, out_ready=1 -> in_ready=8'b0000_1000 each cycle; out_data=A5, out_ch=3 from the cycle after.
2. RR mode after reset, in_valid=8'hFF, out_ready=1, distinct data per channel -> out_ch sequence 0,1,2,...,7,0, one word per cycle, no bubbles.
3. RR mode, in_valid=8'b1000_0010, rr_ptr=1 -> next grant is ch7, then ch1 (wrap-around); channels 0 and 2..6 are never granted.
4. Back-pressure: out_valid=1, hold out_ready=0 for 4 cycles -> out_data/out_ch stable and in_ready=0; raise out_ready -> the next word loads on that same edge.
5. N_CH=6 build, fixed mode, sel=7 -> sel_err=1 the next cycle, in_ready=0, out_valid drops after the pending word is consumed.
6. Reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_ch=0; the first RR grant afterwards goes to the lowest valid channel.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N-channel valid/ready stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Keeps index fields at least one bit wide even for a single channel.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: first requester after ptr, wrapping.
module rr_arbiter_n #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    localparam logic [SEL_W:0] N_W = (SEL_W + 1)'(N_CH);

    logic [SEL_W:0] idx;

    // One extra bit holds ptr+1+k before folding back below N_CH.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = {1'b0, ptr} + (SEL_W + 1)'(k + 1);
            if (idx >= N_W) begin
                idx = idx - N_W;
            end
            if (!gnt_valid && req[idx[SEL_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel stream mux with fixed-select or round-robin grant and one
// registered, back-pressured output stage.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = clog2_min1(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sel_err
);

    localparam logic [SEL_W:0] N_W = (SEL_W + 1)'(N_CH);

    logic [SEL_W-1:0]  rr_ptr;
    logic              rr_valid;
    logic [SEL_W-1:0]  rr_idx;
    logic              sel_ok;
    logic              fix_valid;
    logic              gnt_valid;
    logic [SEL_W-1:0]  gnt_idx;
    logic [DATA_W-1:0] gnt_data;
    logic              load_en;
    logic              fire;

    rr_arbiter_n #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Widened compare so non-power-of-two channel counts can flag bad selects.
    assign sel_ok    = ({1'b0, sel} < N_W);
    assign fix_valid = sel_ok && in_valid[sel];

    assign gnt_valid = (mode == MODE_RR) ? rr_valid : fix_valid;
    assign gnt_idx   = (mode == MODE_RR) ? rr_idx   : sel;
    assign load_en   = !out_valid || out_ready;
    assign fire      = load_en && gnt_valid;

    always_comb begin
        in_ready = '0;
        if (fire) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            sel_err   <= 1'b0;
            rr_ptr    <= SEL_W'(N_CH - 1);
        end else begin
            sel_err <= (mode == MODE_FIXED) && !sel_ok;
            if (fire) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_ch    <= gnt_idx;
                if (mode == MODE_RR) begin
                    rr_ptr <= gnt_idx;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: 8-channel and 6-channel builds against a
// cycle-level reference model derived from the grant rules.
module tb_stream_mux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8 = 1'b1, mode8 = 1'b0, ordy8 = 1'b0;
    logic [2:0]  sel8 = '0;
    logic [63:0] data8 = '0;
    logic [7:0]  valid8 = '0;
    logic [7:0]  rdy8, odata8;
    logic [2:0]  och8;
    logic        ov8, err8;

    logic        rst6 = 1'b1, mode6 = 1'b0, ordy6 = 1'b0;
    logic [2:0]  sel6 = '0;
    logic [47:0] data6 = '0;
    logic [5:0]  valid6 = '0;
    logic [5:0]  rdy6;
    logic [7:0]  odata6;
    logic [2:0]  och6;
    logic        ov6, err6;

    stream_mux_n #(.N_CH(8), .DATA_W(8)) dut8 (
        .clk(clk), .rst(rst8), .mode(mode8), .sel(sel8), .in_data(data8),
        .in_valid(valid8), .in_ready(rdy8), .out_data(odata8), .out_ch(och8),
        .out_valid(ov8), .out_ready(ordy8), .sel_err(err8)
    );

    stream_mux_n #(.N_CH(6), .DATA_W(8)) dut6 (
        .clk(clk), .rst(rst6), .mode(mode6), .sel(sel6), .in_data(data6),
        .in_valid(valid6), .in_ready(rdy6), .out_data(odata6), .out_ch(och6),
        .out_valid(ov6), .out_ready(ordy6), .sel_err(err6)
    );

    int tests = 0;
    int fails = 0;

    logic       m8_ov = 1'b0, m8_err = 1'b0, m6_ov = 1'b0, m6_err = 1'b0;
    logic [7:0] m8_od = '0, m6_od = '0;
    int         m8_oc = 0, m8_ptr = 7, m6_oc = 0, m6_ptr = 5;

    // Grant = valid channel at smallest cyclic distance after ptr (RR), or sel.
    function automatic int pick(input int n, input logic md, input int s,
                                input logic [15:0] v, input int ptr);
        int best, bestd, d;
        if (md == 1'b0) return (s < n && v[s]) ? s : -1;
        best  = -1;
        bestd = n;
        for (int i = 0; i < n; i++) begin
            if (v[i]) begin
                d = (i - ptr - 1 + 2 * n) % n;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [15:0] exp_ready(input int n, input logic md, input int s,
                                              input logic [15:0] v, input logic ov,
                                              input logic ordy, input int ptr);
        int g;
        g = pick(n, md, s, v, ptr);
        exp_ready = '0;
        if ((!ov || ordy) && g >= 0) exp_ready[g] = 1'b1;
    endfunction

    task automatic model_step(input int n, input logic r, input logic md, input int s,
                              input logic [15:0] v, input logic [127:0] d, input logic ordy,
                              inout logic ov, inout logic [7:0] od, inout int oc,
                              inout int ptr, inout logic err);
        int g;
        if (r) begin
            ov = 1'b0; od = '0; oc = 0; ptr = n - 1; err = 1'b0;
        end else begin
            g   = pick(n, md, s, v, ptr);
            err = (md == 1'b0) && (s >= n);
            if ((!ov || ordy) && g >= 0) begin
                ov = 1'b1;
                od = d[g*8 +: 8];
                oc = g;
                if (md) ptr = g;
            end else if (ov && ordy) begin
                ov = 1'b0;
            end
        end
    endtask

    task automatic adv();
        model_step(8, rst8, mode8, int'(sel8), 16'(valid8), 128'(data8), ordy8,
                   m8_ov, m8_od, m8_oc, m8_ptr, m8_err);
        model_step(6, rst6, mode6, int'(sel6), 16'(valid6), 128'(data6), ordy6,
                   m6_ov, m6_od, m6_oc, m6_ptr, m6_err);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst8 = 1'b1; mode8 = 1'b1; valid8 = 8'hFF; ordy8 = 1'b1;
        data8 = {$urandom, $urandom};
        adv();
        adv();
        tests++;
        if ({ov8, odata8, och8, err8} !== 13'h0) begin
            fails++;
            $display("FAIL reset_state: got ov=%b data=%h ch=%0d err=%b, want all zero",
                     ov8, odata8, och8, err8);
        end
        rst8 = 1'b0;
        #1;
        tests++;
        if (rdy8 !== 8'h01) begin
            fails++;
            $display("FAIL reset_first_rr: got in_ready=%b want 00000001", rdy8);
        end
    endtask

    task automatic test_fixed();
        mode8 = 1'b0; sel8 = 3'd3; valid8 = 8'hFF; ordy8 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            data8 = {$urandom, $urandom};
            data8[31:24] = 8'hA5;
            #1;
            tests++;
            if (rdy8 !== 8'h08) begin
                fails++;
                $display("FAIL fixed_ready: cycle %0d got %b want 00001000", c, rdy8);
            end
            if (c > 0) begin
                tests++;
                if ({ov8, och8, odata8} !== {1'b1, 3'd3, 8'hA5}) begin
                    fails++;
                    $display("FAIL fixed_out: cycle %0d got v=%b ch=%0d d=%h want v=1 ch=3 d=a5",
                             c, ov8, och8, odata8);
                end
            end
            adv();
        end
    endtask

    task automatic test_rr_sweep();
        rst8 = 1'b1;
        adv();
        rst8 = 1'b0; mode8 = 1'b1; valid8 = 8'hFF; ordy8 = 1'b1;
        for (int i = 0; i < 8; i++) data8[i*8 +: 8] = 8'(8'h10 + i);
        for (int c = 0; c < 9; c++) begin
            adv();
            tests++;
            if ({ov8, och8, odata8} !== {1'b1, 3'(c % 8), 8'(16 + c % 8)}) begin
                fails++;
                $display("FAIL rr_sweep: word %0d got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                         c, ov8, och8, odata8, c % 8, 16 + c % 8);
            end
        end
    endtask

    task automatic test_rr_wrap();
        valid8 = 8'b0000_0010;
        adv();
        valid8 = 8'b1000_0010;
        for (int j = 0; j < 6; j++) begin
            #1;
            tests++;
            if (rdy8 !== ((j % 2 == 0) ? 8'h80 : 8'h02)) begin
                fails++;
                $display("FAIL rr_wrap_ready: step %0d got %b", j, rdy8);
            end
            adv();
            tests++;
            if (och8 !== ((j % 2 == 0) ? 3'd7 : 3'd1)) begin
                fails++;
                $display("FAIL rr_wrap_ch: step %0d got %0d want %0d", j, och8,
                         (j % 2 == 0) ? 7 : 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] er;
        int g;
        mode8 = 1'b1; valid8 = 8'hFF; ordy8 = 1'b1; data8 = {$urandom, $urandom};
        adv();
        ordy8 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            data8 = {$urandom, $urandom};
            #1;
            er = exp_ready(8, mode8, int'(sel8), 16'(valid8), m8_ov, ordy8, m8_ptr);
            tests++;
            if ({rdy8, ov8, och8, odata8} !== {er[7:0], m8_ov, m8_oc[2:0], m8_od} || rdy8 !== 8'h00) begin
                fails++;
                $display("FAIL bp_hold: cycle %0d got rdy=%b v=%b ch=%0d d=%h want rdy=%b v=%b ch=%0d d=%h",
                         c, rdy8, ov8, och8, odata8, er[7:0], m8_ov, m8_oc, m8_od);
            end
            adv();
        end
        ordy8 = 1'b1;
        #1;
        g = pick(8, mode8, int'(sel8), 16'(valid8), m8_ptr);
        tests++;
        if (rdy8 !== 8'(1 << g)) begin
            fails++;
            $display("FAIL bp_release_ready: got %b want ch %0d", rdy8, g);
        end
        adv();
        tests++;
        if ({ov8, och8, odata8} !== {1'b1, 3'(g), data8[g*8 +: 8]}) begin
            fails++;
            $display("FAIL bp_release_load: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                     ov8, och8, odata8, g, data8[g*8 +: 8]);
        end
    endtask

    task automatic test_reset_mid();
        mode8 = 1'b1; valid8 = 8'hFF; ordy8 = 1'b1; data8 = {$urandom, $urandom};
        adv();
        ordy8 = 1'b0;
        adv();
        tests++;
        if (ov8 !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_pre: got out_valid=%b want 1", ov8);
        end
        rst8 = 1'b1;
        adv();
        tests++;
        if ({ov8, odata8, och8} !== 12'h0) begin
            fails++;
            $display("FAIL rstmid_clear: got v=%b d=%h ch=%0d want 0", ov8, odata8, och8);
        end
        rst8 = 1'b0; valid8 = 8'b0011_0100; ordy8 = 1'b1;
        #1;
        tests++;
        if (rdy8 !== 8'h04) begin
            fails++;
            $display("FAIL rstmid_grant: got %b want 00000100", rdy8);
        end
        adv();
        tests++;
        if ({ov8, och8, odata8} !== {1'b1, 3'd2, data8[23:16]}) begin
            fails++;
            $display("FAIL rstmid_load: got v=%b ch=%0d d=%h want v=1 ch=2 d=%h",
                     ov8, och8, odata8, data8[23:16]);
        end
    endtask

    task automatic test_random8();
        logic [15:0] er;
        for (int c = 0; c < 400; c++) begin
            rst8   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 7) == 0) mode8 = ~mode8;
            sel8   = 3'($urandom);
            valid8 = 8'($urandom & $urandom);
            ordy8  = ($urandom_range(0, 3) != 0);
            data8  = {$urandom, $urandom};
            #1;
            er = exp_ready(8, mode8, int'(sel8), 16'(valid8), m8_ov, ordy8, m8_ptr);
            tests++;
            if ({rdy8, ov8, och8, odata8, err8} !== {er[7:0], m8_ov, m8_oc[2:0], m8_od, m8_err}) begin
                fails++;
                $display("FAIL rand8: cycle %0d got rdy=%b v=%b ch=%0d d=%h e=%b want rdy=%b v=%b ch=%0d d=%h e=%b",
                         c, rdy8, ov8, och8, odata8, err8, er[7:0], m8_ov, m8_oc, m8_od, m8_err);
            end
            adv();
        end
        rst8 = 1'b0;
    endtask

    task automatic test_sel_err6();
        rst6 = 1'b1;
        adv();
        rst6 = 1'b0; mode6 = 1'b0; sel6 = 3'd2; valid6 = 6'h3F; ordy6 = 1'b0;
        data6 = {16'($urandom), $urandom};
        adv();
        sel6 = 3'd7;
        #1;
        tests++;
        if (rdy6 !== 6'h00) begin
            fails++;
            $display("FAIL sel_err_ready: got %b want 000000", rdy6);
        end
        adv();
        tests++;
        if ({err6, ov6, och6} !== {1'b1, 1'b1, 3'd2}) begin
            fails++;
            $display("FAIL sel_err_flag: got err=%b v=%b ch=%0d want err=1 v=1 ch=2", err6, ov6, och6);
        end
        ordy6 = 1'b1;
        #1;
        tests++;
        if (rdy6 !== 6'h00) begin
            fails++;
            $display("FAIL sel_err_noready: got %b want 000000", rdy6);
        end
        adv();
        tests++;
        if ({ov6, err6} !== 2'b01) begin
            fails++;
            $display("FAIL sel_err_drain: got v=%b err=%b want v=0 err=1", ov6, err6);
        end
    endtask

    task automatic test_random6();
        logic [15:0] er;
        for (int c = 0; c < 300; c++) begin
            rst6   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 7) == 0) mode6 = ~mode6;
            sel6   = 3'($urandom);
            valid6 = 6'($urandom & $urandom);
            ordy6  = ($urandom_range(0, 3) != 0);
            data6  = {16'($urandom), $urandom};
            #1;
            er = exp_ready(6, mode6, int'(sel6), 16'(valid6), m6_ov, ordy6, m6_ptr);
            tests++;
            if ({rdy6, ov6, och6, odata6, err6} !== {er[5:0], m6_ov, m6_oc[2:0], m6_od, m6_err}) begin
                fails++;
                $display("FAIL rand6: cycle %0d got rdy=%b v=%b ch=%0d d=%h e=%b want rdy=%b v=%b ch=%0d d=%h e=%b",
                         c, rdy6, ov6, och6, odata6, err6, er[5:0], m6_ov, m6_oc, m6_od, m6_err);
            end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_sweep();
        test_rr_wrap();
        test_backpressure();
        test_reset_mid();
        test_random8();
        test_sel_err6();
        test_random6();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
